alu_ctrl_seq: RTL and testbench

//  Registered, parametrised successor to the combinational ALU-control decode.
//  - Decodes aluop/func into an ALU operation select (op_sel).
//  - Adds a valid/ready handshake and sequencing for multi-cycle ops (MUL/DIV).
//  - Sits between the main decoder and the ALU/MD unit; drives a stall to the pipeline.

---
 rtl/alu_ctrl_seq.sv | 109 ++++++++++
 tb/tb_alu_ctrl_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// Registered ALU-control decode with a valid/ready handshake and sequencing for
// multi-cycle MUL/DIV ops; mc_busy stalls the pipeline while one is in flight.
module alu_ctrl_seq #(
    parameter int              FUNC_W   = 4,
    parameter int              OP_W     = 3,
    parameter logic [OP_W-1:0] ADD_SEL  = 3'b100,
    parameter logic [OP_W-1:0] SUB_SEL  = 3'b101,
    parameter logic [OP_W-1:0] IDLE_SEL = 3'b000,
    parameter int              MUL_LAT  = 4,
    parameter int              DIV_LAT  = 8,
    parameter int              CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        aluop,
    input  logic [FUNC_W-1:0] func,
    output logic [OP_W-1:0]   op_sel,
    output logic              op_valid,
    output logic              mc_busy,
    output logic              mc_done
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    // The counter is loaded with LAT-1 so that cnt==0 marks the last busy cycle.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_sel_q, op_sel_d;
    logic              op_valid_q, op_valid_d;
    logic              accept;

    assign mc_busy  = (state_q == S_BUSY);
    assign mc_done  = mc_busy && (cnt_q == '0);
    assign in_ready = ~mc_busy;
    assign accept   = in_valid && in_ready;
    assign op_sel   = op_sel_q;
    assign op_valid = op_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_sel_q   <= IDLE_SEL;
            op_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_sel_q   <= op_sel_d;
            op_valid_q <= op_valid_d;
        end
    end

    // Flush overrides everything, including an input offered in the same cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_sel_d   = op_sel_q;
        op_valid_d = 1'b0;
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            op_sel_d = IDLE_SEL;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (aluop[0]) begin
                            op_sel_d   = ADD_SEL;
                            op_valid_d = 1'b1;
                        end else if (aluop[1]) begin
                            op_sel_d   = SUB_SEL;
                            op_valid_d = 1'b1;
                        end else if (aluop[2]) begin
                            op_sel_d   = func[OP_W-1:0];
                            op_valid_d = 1'b1;
                            if (func[FUNC_W-1]) begin
                                state_d = S_BUSY;
                                cnt_d   = func[0] ? DIV_CNT : MUL_CNT;
                            end
                        end else begin
                            op_sel_d = IDLE_SEL;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: a scoreboard queue holds the op_sel expected
// for every accepted op and is drained whenever the DUT pulses op_valid.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] aluop = 3'b000;
    logic [3:0] func = 4'b0000;
    logic       in_ready;
    logic [2:0] op_sel;
    logic       op_valid;
    logic       mc_busy;
    logic       mc_done;

    int         vectors = 0;
    int         miscompares = 0;
    logic [2:0] exp_q[$];
    logic [2:0] sb_exp;

    always #5 clk = ~clk;

    alu_ctrl_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .aluop    (aluop),
        .func     (func),
        .op_sel   (op_sel),
        .op_valid (op_valid),
        .mc_busy  (mc_busy),
        .mc_done  (mc_done)
    );

    function automatic logic [2:0] ref_sel(input logic [2:0] a, input logic [3:0] f);
        if (a[0])      return 3'b100;
        else if (a[1]) return 3'b101;
        else if (a[2]) return f[2:0];
        else           return 3'b000;
    endfunction

    // Offers an op; when the bench expects it to be accepted and it issues, its op_sel is queued.
    task automatic offer(input logic [2:0] a, input logic [3:0] f, input bit accepted);
        aluop    = a;
        func     = f;
        in_valid = 1'b1;
        if (accepted && a != 3'b000) exp_q.push_back(ref_sel(a, f));
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        aluop    = 3'b000;
        func     = 4'b0000;
    endtask

    always @(negedge clk) begin
        if (rst_n && op_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL sb_unexpected: op_valid=1 op_sel=%b, required no issue", op_sel);
            end else begin
                sb_exp = exp_q.pop_front();
                if (op_sel !== sb_exp) begin
                    miscompares++;
                    $display("[TB] FAIL sb_op_sel: got %b, required %b", op_sel, sb_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        idle_in();
        repeat (2) @(negedge clk);
        vectors++;
        if ({op_sel, op_valid, mc_busy, mc_done, in_ready} !== 7'b000_0001) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %b, required %b",
                     {op_sel, op_valid, mc_busy, mc_done, in_ready}, 7'b000_0001);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [2:0] al [3];
        al = '{3'b001, 3'b010, 3'b100};
        for (int i = 0; i < 3; i++) begin
            offer(al[i], 4'b0110, 1'b1);
            @(negedge clk);
            vectors++;
            if (op_valid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL b2b_valid[%0d]: got %b, required 1", i, op_valid);
            end
        end
        idle_in();
        @(negedge clk);
        vectors++;
        if ({op_valid, op_sel} !== 4'b0_110) begin
            miscompares++;
            $display("[TB] FAIL b2b_hold: got valid/sel %b, required 0110", {op_valid, op_sel});
        end
    endtask

    task automatic test_mul();
        offer(3'b100, 4'b1000, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) idle_in();
            vectors++;
            if ({mc_busy, in_ready, op_valid, mc_done} !== {1'b1, 1'b0, (k == 1), (k == 4)}) begin
                miscompares++;
                $display("[TB] FAIL mul_cycle[%0d]: busy/ready/valid/done got %b, required %b", k,
                         {mc_busy, in_ready, op_valid, mc_done}, {1'b1, 1'b0, (k == 1), (k == 4)});
            end
        end
        @(negedge clk);
        vectors++;
        if ({mc_busy, in_ready, mc_done} !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL mul_end: busy/ready/done got %b, required 010", {mc_busy, in_ready, mc_done});
        end
    endtask

    task automatic test_div_hold();
        offer(3'b100, 4'b1001, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) offer(3'b001, 4'b0000, 1'b0);
            vectors++;
            if ({mc_busy, in_ready, op_valid, mc_done, op_sel} !==
                {1'b1, 1'b0, (k == 1), (k == 8), 3'b001}) begin
                miscompares++;
                $display("[TB] FAIL div_cycle[%0d]: busy/ready/valid/done/sel got %b, required %b", k,
                         {mc_busy, in_ready, op_valid, mc_done, op_sel},
                         {1'b1, 1'b0, (k == 1), (k == 8), 3'b001});
            end
        end
        @(negedge clk);
        vectors++;
        if ({mc_busy, in_ready, op_valid} !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL div_end: busy/ready/valid got %b, required 010", {mc_busy, in_ready, op_valid});
        end
        offer(3'b001, 4'b0000, 1'b1);
        @(negedge clk);
        idle_in();
        vectors++;
        if (op_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL div_next_accept: op_valid got %b, required 1", op_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        offer(3'b100, 4'b1001, 1'b1);
        @(negedge clk);
        idle_in();
        @(negedge clk);
        flush = 1'b1;
        offer(3'b001, 4'b0000, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        idle_in();
        vectors++;
        if ({mc_busy, op_sel, in_ready, op_valid, mc_done} !== 7'b0_000_100) begin
            miscompares++;
            $display("[TB] FAIL flush_busy: busy/sel/ready/valid/done got %b, required 0000100",
                     {mc_busy, op_sel, in_ready, op_valid, mc_done});
        end
        offer(3'b001, 4'b0000, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        offer(3'b010, 4'b0000, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        idle_in();
        vectors++;
        if ({op_valid, op_sel} !== 4'b0_000) begin
            miscompares++;
            $display("[TB] FAIL flush_idle: valid/sel got %b, required 0000", {op_valid, op_sel});
        end
        offer(3'b100, 4'b1000, 1'b1);
        @(negedge clk);
        idle_in();
        repeat (3) @(negedge clk);
        flush = 1'b1;
        vectors++;
        if ({mc_busy, mc_done} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL flush_on_done: busy/done got %b, required 11", {mc_busy, mc_done});
        end
        @(negedge clk);
        flush = 1'b0;
        vectors++;
        if ({mc_busy, in_ready, mc_done} !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL flush_after_done: busy/ready/done got %b, required 010",
                     {mc_busy, in_ready, mc_done});
        end
    endtask

    task automatic test_priority();
        offer(3'b011, 4'b0110, 1'b1);
        @(negedge clk);
        offer(3'b110, 4'b0110, 1'b1);
        @(negedge clk);
        offer(3'b100, 4'b0111, 1'b1);
        @(negedge clk);
        offer(3'b000, 4'b0101, 1'b1);
        @(negedge clk);
        vectors++;
        if ({op_valid, op_sel} !== 4'b0_000) begin
            miscompares++;
            $display("[TB] FAIL aluop_zero: valid/sel got %b, required 0000", {op_valid, op_sel});
        end
        offer(3'b001, 4'b0000, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        aluop    = 3'b010;
        @(negedge clk);
        aluop    = 3'b000;
        @(negedge clk);
        vectors++;
        if ({op_valid, op_sel} !== 4'b0_100) begin
            miscompares++;
            $display("[TB] FAIL hold_no_accept: valid/sel got %b, required 0100", {op_valid, op_sel});
        end
        idle_in();
    endtask

    task automatic test_async_reset_busy();
        offer(3'b100, 4'b1000, 1'b1);
        @(negedge clk);
        idle_in();
        vectors++;
        if (mc_busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL areset_pre_busy: mc_busy got %b, required 1", mc_busy);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({op_sel, op_valid, mc_busy, mc_done, in_ready} !== 7'b000_0001) begin
            miscompares++;
            $display("[TB] FAIL areset_mid_busy: got %b, required %b",
                     {op_sel, op_valid, mc_busy, mc_done, in_ready}, 7'b000_0001);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mul();
        test_div_hold();
        test_flush();
        test_priority();
        test_async_reset_busy();
        idle_in();
        repeat (2) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL sb_leftover: %0d ops still queued, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
